// File: rtl/mem_bank_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bank_pkg
//  Description : Shared definitions for the banked memory array: init-fill
//                FSM state encoding, byte-to-word address offset and the
//                word-index width helper.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_bank_pkg;

  // Addresses are byte addresses of 32-bit words, so the word index starts
  // at bit 2.
  localparam int ADDR_LSB = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } init_state_t;

  // Number of address bits needed to index DEPTH words.
  function automatic int idx_width(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_bank.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bank
//  Description : One memory bank: a single write port and one registered,
//                read-first read port. Contents are never reset; only the
//                read register is.
//  Ports       : clk, rst_n          - clock, synchronous active-low reset
//                i_we/i_waddr/i_wdata - write enable, word index, data
//                i_raddr             - read word index
//                o_rdata             - registered read data
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_bank
  import mem_bank_pkg::*;
#(
  parameter int DEPTH      = 128,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_W      = idx_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_we,
  input  logic [IDX_W-1:0]      i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [IDX_W-1:0]      i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Reads sample the array before this edge's write lands (read-first).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/mem_bank_array.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bank_array
//  Description : NUM_BANKS independent word banks with per-bank read/write
//                ports, a masked broadcast load and a whole-array init fill.
//                Per-bank write priority: fill > accepted load > we[i];
//                a dropped we[i] sets a sticky wr_conflict[i].
//  Ports       : clk, rst_n                 - clock, sync active-low reset
//                we, addw, din              - per-bank writes (flattened)
//                addr, dout                 - per-bank reads (flattened)
//                ld_valid/ld_ready/ld_mask/ld_addr/ld_data - broadcast load
//                init_start/init_value/init_busy/init_done - array fill
//                wr_conflict                - sticky dropped-write flags
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_bank_array
  import mem_bank_pkg::*;
#(
  parameter int NUM_BANKS  = 16,
  parameter int DEPTH      = 128,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_BANKS-1:0]            we,
  input  logic [NUM_BANKS*ADDR_WIDTH-1:0] addr,
  input  logic [NUM_BANKS*ADDR_WIDTH-1:0] addw,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0] din,
  output logic [NUM_BANKS*DATA_WIDTH-1:0] dout,
  input  logic                            ld_valid,
  output logic                            ld_ready,
  input  logic [NUM_BANKS-1:0]            ld_mask,
  input  logic [ADDR_WIDTH-1:0]           ld_addr,
  input  logic [DATA_WIDTH-1:0]           ld_data,
  input  logic                            init_start,
  input  logic [DATA_WIDTH-1:0]           init_value,
  output logic                            init_busy,
  output logic                            init_done,
  output logic [NUM_BANKS-1:0]            wr_conflict
);

  localparam int IW = idx_width(DEPTH);

  init_state_t           r_state;
  init_state_t           w_state_nxt;
  logic [IW-1:0]         r_cnt;
  logic [DATA_WIDTH-1:0] r_val;
  logic [NUM_BANKS-1:0]  r_conf;
  logic [NUM_BANKS-1:0]  w_conf;
  logic                  w_busy;
  logic                  w_done;
  logic                  w_fill;
  logic                  w_start;
  logic                  w_ld_acc;
  logic [IW-1:0]         w_ld_idx;
  logic                  w_unused_addr_bits;

  // Only the word-index field of each address matters.
  assign w_unused_addr_bits = ^{addr, addw, ld_addr};

  // ---------------- init FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------- init FSM: next state ----------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (init_start)                  w_state_nxt = ST_FILL;
      ST_FILL: if (r_cnt == IW'(DEPTH - 1))     w_state_nxt = ST_DONE;
      ST_DONE:                                  w_state_nxt = ST_IDLE;
      default:                                  w_state_nxt = ST_IDLE;
    endcase
  end

  // ---------------- init FSM: outputs ----------------
  always_comb begin
    w_fill = 1'b0;
    w_done = 1'b0;
    w_busy = 1'b0;
    case (r_state)
      ST_FILL: begin w_fill = 1'b1; w_busy = 1'b1; end
      ST_DONE: begin w_done = 1'b1; w_busy = 1'b1; end
      default: ;
    endcase
  end

  assign init_busy = w_busy;
  assign init_done = w_done;
  assign ld_ready  = ~w_busy;
  assign w_start   = init_start & ~w_busy;
  assign w_ld_acc  = ld_valid & ~w_busy;
  assign w_ld_idx  = ld_addr[ADDR_LSB +: IW];

  // Fill counter; wraps back to 0 naturally after the last word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_start) begin
      r_cnt <= '0;
    end else if (w_fill) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_start) begin
      r_val <= init_value;
    end
  end

  // A conflict raised on the same edge as an accepted init_start survives
  // the clear, so no dropped write ever goes unreported.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_conf <= '0;
    end else begin
      r_conf <= (w_start ? '0 : r_conf) | w_conf;
    end
  end

  assign wr_conflict = r_conf;

  // ---------------- per-bank write muxing and banks ----------------
  for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
    logic                  w_ld_hit;
    logic                  w_wen;
    logic [IW-1:0]         w_wr_idx;
    logic [IW-1:0]         w_rd_idx;
    logic [DATA_WIDTH-1:0] w_wdata;

    assign w_ld_hit  = w_ld_acc & ld_mask[i];
    assign w_rd_idx  = addr[i*ADDR_WIDTH + ADDR_LSB +: IW];
    // Writes are held off while in reset so an aborted fill stops cleanly.
    assign w_conf[i] = rst_n & we[i] & (w_fill | w_ld_hit);

    always_comb begin
      w_wen    = 1'b0;
      w_wr_idx = addw[i*ADDR_WIDTH + ADDR_LSB +: IW];
      w_wdata  = din[i*DATA_WIDTH +: DATA_WIDTH];
      if (rst_n) begin
        if (w_fill) begin
          w_wen    = 1'b1;
          w_wr_idx = r_cnt;
          w_wdata  = r_val;
        end else if (w_ld_hit) begin
          w_wen    = 1'b1;
          w_wr_idx = w_ld_idx;
          w_wdata  = ld_data;
        end else if (we[i]) begin
          w_wen    = 1'b1;
        end
      end
    end

    mem_bank #(
      .DEPTH      (DEPTH),
      .DATA_WIDTH (DATA_WIDTH),
      .IDX_W      (IW)
    ) u_bank (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_we    (w_wen),
      .i_waddr (w_wr_idx),
      .i_wdata (w_wdata),
      .i_raddr (w_rd_idx),
      .o_rdata (dout[i*DATA_WIDTH +: DATA_WIDTH])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_bank_array.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_bank_array
//  Description : Self-checking bench for mem_bank_array: directed table,
//                hand-written corner sequences and random traffic, all
//                compared against a word-array reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bank_array;

  localparam int NB    = 16;
  localparam int DEPTH = 128;
  localparam int AW    = 32;
  localparam int DW    = 32;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NB-1:0]       we;
  logic [NB*AW-1:0]    addr;
  logic [NB*AW-1:0]    addw;
  logic [NB*DW-1:0]    din;
  logic [NB*DW-1:0]    dout;
  logic                ld_valid;
  logic                ld_ready;
  logic [NB-1:0]       ld_mask;
  logic [AW-1:0]       ld_addr;
  logic [DW-1:0]       ld_data;
  logic                init_start;
  logic [DW-1:0]       init_value;
  logic                init_busy;
  logic                init_done;
  logic [NB-1:0]       wr_conflict;

  logic [AW-1:0] b_addr [NB];
  logic [AW-1:0] b_addw [NB];
  logic [DW-1:0] b_din  [NB];

  always_comb begin
    for (int i = 0; i < NB; i++) begin
      addr[i*AW +: AW] = b_addr[i];
      addw[i*AW +: AW] = b_addw[i];
      din[i*DW +: DW]  = b_din[i];
    end
  end

  always #5 clk = ~clk;

  mem_bank_array #(
    .NUM_BANKS (NB), .DEPTH (DEPTH), .ADDR_WIDTH (AW), .DATA_WIDTH (DW)
  ) dut (
    .clk (clk), .rst_n (rst_n), .we (we), .addr (addr), .addw (addw),
    .din (din), .dout (dout), .ld_valid (ld_valid), .ld_ready (ld_ready),
    .ld_mask (ld_mask), .ld_addr (ld_addr), .ld_data (ld_data),
    .init_start (init_start), .init_value (init_value),
    .init_busy (init_busy), .init_done (init_done),
    .wr_conflict (wr_conflict)
  );

  // ---------------- reference model ----------------
  logic [DW-1:0] m_mem   [NB][DEPTH];
  bit            m_known [NB][DEPTH];
  int            m_fill = -1;   // next word to fill, -1 when not filling
  bit            m_done = 1'b0;
  logic [DW-1:0] m_val;
  logic [NB-1:0] m_conf = '0;

  int n_checks = 0;
  int n_pass   = 0;

  function automatic int widx(input logic [AW-1:0] a);
    return int'(a / 4) % DEPTH;
  endfunction

  task automatic chk(input string name, input logic [NB*DW-1:0] act,
                     input logic [NB*DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic mwrite(input int b, input int w, input logic [DW-1:0] d);
    m_mem[b][w]   = d;
    m_known[b][w] = 1'b1;
  endtask

  // One clock: predict from pre-edge inputs, clock, then compare.
  task automatic tick();
    logic [NB*DW-1:0] exp_d, care;
    logic [NB-1:0]    newc;
    bit               busy, acc, start;
    busy = (m_fill >= 0) || m_done;
    for (int b = 0; b < NB; b++) begin
      int w;
      w = widx(b_addr[b]);
      exp_d[b*DW +: DW] = rst_n ? m_mem[b][w] : '0;
      care[b*DW +: DW]  = (!rst_n || m_known[b][w]) ? '1 : '0;
    end
    if (rst_n) begin
      acc   = ld_valid && !busy;
      start = init_start && !busy;
      newc  = '0;
      for (int b = 0; b < NB; b++) begin
        bit higher;
        higher = (m_fill >= 0) || (acc && ld_mask[b]);
        if (m_fill >= 0) mwrite(b, m_fill, m_val);
        else if (acc && ld_mask[b]) mwrite(b, widx(ld_addr), ld_data);
        if (we[b]) begin
          if (higher) newc[b] = 1'b1;
          else mwrite(b, widx(b_addw[b]), b_din[b]);
        end
      end
      m_conf = (start ? '0 : m_conf) | newc;
      if (m_fill >= 0) begin
        if (m_fill == DEPTH - 1) begin m_fill = -1; m_done = 1'b1; end
        else m_fill++;
      end else if (m_done) begin
        m_done = 1'b0;
      end else if (start) begin
        m_fill = 0;
        m_val  = init_value;
      end
    end else begin
      m_fill = -1;
      m_done = 1'b0;
      m_conf = '0;
    end
    @(posedge clk);
    #1;
    chk("dout", dout & care, exp_d & care);
    chk("wr_conflict", wr_conflict, m_conf);
    chk("init_busy", init_busy, (m_fill >= 0) || m_done);
    chk("init_done", init_done, m_done);
    chk("ld_ready", ld_ready, !((m_fill >= 0) || m_done));
  endtask

  function automatic logic [DW-1:0] slice(input int b);
    return dout[b*DW +: DW];
  endfunction

  typedef struct {
    int            wbank;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [AW-1:0] raddr;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int busy_cnt, done_cnt, nready, acc_cnt;
    bit all_ok;

    vecs[0] = '{3, 32'h10,  32'hDEADBEEF, 32'h10,  32'hDEADBEEF};
    vecs[1] = '{5, 32'h200, 32'h11112222, 32'h0,   32'h11112222};
    vecs[2] = '{7, 32'h1FF, 32'hCAFE0001, 32'h1FC, 32'hCAFE0001};
    vecs[3] = '{0, 32'h13,  32'h0BADF00D, 32'h10,  32'h0BADF00D};

    rst_n = 1'b0; we = '0; ld_valid = 1'b0; ld_mask = '0; ld_addr = '0;
    ld_data = '0; init_start = 1'b0; init_value = '0;
    for (int i = 0; i < NB; i++) begin
      b_addr[i] = '0; b_addw[i] = '0; b_din[i] = '0;
    end

    // Reset state
    tick(); tick();
    chk("reset_dout", dout, '0);
    rst_n = 1'b1;

    // Full fill with A5A5A5A5
    init_value = 32'hA5A5A5A5; init_start = 1'b1;
    tick();
    init_start = 1'b0;
    busy_cnt = init_busy ? 1 : 0;
    done_cnt = 0;
    for (int k = 0; k < 300 && init_busy; k++) begin
      tick();
      if (init_busy) busy_cnt++;
      if (init_done) done_cnt++;
    end
    chk("fill_busy_cycles", busy_cnt, 129);
    chk("fill_done_pulses", done_cnt, 1);

    all_ok = 1'b1;
    for (int w = 0; w < DEPTH; w++) begin
      for (int b = 0; b < NB; b++) b_addr[b] = AW'(w * 4 + b * 512);
      tick();
      if (dout !== {NB{32'hA5A5A5A5}}) all_ok = 1'b0;
    end
    chk("fill_sweep", all_ok, 1);

    // Directed write/read table
    for (int v = 0; v < 4; v++) begin
      we = '0; we[vecs[v].wbank] = 1'b1;
      b_addw[vecs[v].wbank] = vecs[v].waddr;
      b_din[vecs[v].wbank]  = vecs[v].wdata;
      tick();
      we = '0;
      b_addr[vecs[v].wbank] = vecs[v].raddr;
      tick();
      chk($sformatf("table%0d", v), slice(vecs[v].wbank), vecs[v].exp);
    end

    // Load beats per-bank write on bank 0
    ld_valid = 1'b1; ld_addr = 32'h1FC; ld_mask = 16'h0005;
    ld_data = 32'h12345678;
    we = 16'h0001; b_addw[0] = 32'h1FC; b_din[0] = 32'hFFFFFFFF;
    tick();
    ld_valid = 1'b0; we = '0;
    chk("load_conflict", wr_conflict, 16'h0001);
    for (int b = 0; b < NB; b++) b_addr[b] = 32'h1FC;
    tick();
    chk("load_bank0", slice(0), 32'h12345678);
    chk("load_bank2", slice(2), 32'h12345678);

    // Load held across a fill is accepted once, after the fill
    init_value = 32'h3C3C3C3C; init_start = 1'b1;
    tick();
    init_start = 1'b0;
    ld_valid = 1'b1; ld_mask = 16'h0002; ld_addr = 32'h8;
    ld_data = 32'h5555AAAA;
    nready = 0; acc_cnt = 0;
    for (int k = 0; k < 300; k++) begin
      if (ld_ready) begin tick(); acc_cnt++; break; end
      nready++;
      tick();
    end
    ld_valid = 1'b0;
    chk("ld_blocked_cycles", nready, 129);
    chk("ld_accepted", acc_cnt, 1);
    b_addr[1] = 32'h8;
    tick();
    chk("ld_after_fill", slice(1), 32'h5555AAAA);

    // Reset aborts a fill at cnt=40
    init_value = 32'h77777777; init_start = 1'b1;
    tick();
    init_start = 1'b0;
    for (int k = 0; k < 40; k++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_dout", dout, '0);
    chk("abort_idle", init_busy, 1'b0);
    b_addr[0] = 32'd156; b_addr[1] = 32'd160;
    tick();
    chk("abort_word39", slice(0), 32'h77777777);
    chk("abort_word40", slice(1), 32'h3C3C3C3C);

    // Address wrap and same-cycle read/write returns old data
    b_addr[4] = 32'h200; we = 16'h0010; b_addw[4] = 32'h0;
    b_din[4] = 32'h99999999;
    tick();
    we = '0;
    chk("rw_same_old", slice(4), 32'h77777777);
    tick();
    chk("rw_same_new", slice(4), 32'h99999999);

    // Random traffic
    for (int k = 0; k < 600; k++) begin
      rst_n      = ($urandom_range(0, 99) != 0);
      init_start = ($urandom_range(0, 79) == 0);
      init_value = $urandom;
      ld_valid   = ($urandom_range(0, 3) == 0);
      ld_mask    = NB'($urandom);
      ld_addr    = $urandom;
      ld_data    = $urandom;
      we         = NB'($urandom & $urandom);
      for (int b = 0; b < NB; b++) begin
        b_addr[b] = $urandom;
        b_addw[b] = $urandom_range(0, 1023);
        b_din[b]  = $urandom;
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
